ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of the ID/EX latch. Consumes the ID/EX latch outputs, applies operand forwarding, computes the ALU result, and resolves branches and jumps with a redirect handshake to fetch. Owns the EX/MEM pipeline register and presents it to the memory stage.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`word_t` = 32 bits).
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `instr_i, npc_i, curr_pc_i, rdat1_i, rdat2_i` in 32 each: ID/EX latch outputs.
- `regWr_i, dWEN_i, dREN_i, jpSel_i, aluSrc_i, halt_i` in 1 each: ID/EX control.
- `aluOp_i` in `aluop_t`: ALU operation.
- `rdSel_i` in 3: writeback select. 0 = ALU, 1 = dmem, 2 = npc (JAL), 3 = LUI immediate.
- `pcSrc_i` in 2: 0 = sequential, 1 = branch, 2 = jump immediate, 3 = jump register.
- `wb_wen` in 1, `wb_wsel` in 5, `wb_wdat` in 32: MEM/WB writeback, used as a forwarding source.
- `mem_stall` in 1: memory stage not accepting; EX/MEM holds.
- `redirect_ready` in 1: fetch accepts the redirect this cycle.
- `redirect_valid` out 1, `redirect_pc` out 32: taken branch or jump target.
- `ex_busy` out 1: ID/EX must freeze.
- `xm_instr, xm_npc, xm_alu, xm_sdat` out 32 each: EX/MEM register.
- `xm_regWr, xm_dWEN, xm_dREN, xm_halt` out 1 each: EX/MEM control.
- `xm_rdSel` out 3, `xm_wsel` out 5: EX/MEM writeback control.

## Operation
- **Bubble:** `instr_i == 0` is a NOP. It writes a zeroed EX/MEM entry and never redirects.
- **Immediate:**
  - Sign-extended `instr[15:0]` by default.
  - Zero-extended for ANDI, ORI, XORI.
  - Operand B = `aluSrc_i ? imm : fwd_rdat2`.
- **Destination:** `xm_wsel` = `jpSel_i ? 31 : (opcode == RTYPE ? rd : rt)`.
- **Forwarding:** applied per source register (rs, rt), in priority order:
  1. EX/MEM: `xm_regWr && xm_wsel == src && xm_wsel != 0 && !xm_dREN`. The forwarded value is `xm_alu`, or `xm_npc` if `xm_rdSel == 2`.
  2. MEM/WB: `wb_wen && wb_wsel == src && wb_wsel != 0`. The forwarded value is `wb_wdat`.
  3. Otherwise the register-file value.
- Load-use hazards belong to the hazard unit, not this block.
- **Branch:**
  - BEQ is taken on ALU zero; BNE on not-zero.
  - Target = `npc_i + (imm << 2)`.
  - Jump immediate target = `{npc_i[31:28], instr[25:0], 2'b00}`.
  - JR target = forwarded rs.
- **LUI:** `xm_alu` = `{instr[15:0], 16'h0}`.
- `xm_sdat` = forwarded rdat2.
- **FSM** (state in `ex_state_t`):
  - **RUN**
    - A taken control transfer sets `redirect_valid` combinationally.
    - If `redirect_ready` is also high, the transfer completes and the state stays RUN.
    - Otherwise `redirect_pc` is latched and the state goes to REDIR.
    - An instruction with `halt_i` goes to HALTED once it is captured into EX/MEM.
  - **REDIR**
    - `redirect_valid` = 1, driven from the latched PC.
    - `ex_busy` = 1.
    - Returns to RUN on `redirect_ready`.
  - **HALTED**
    - `ex_busy` = 1; no further capture.
    - Only `RST` exits.
- **EX/MEM capture:**
  - Holds when `mem_stall`.
  - Otherwise loads a bubble when in REDIR or HALTED, or when the ID/EX entry is a bubble.
  - Otherwise loads the computed values.
- **Redirect under stall:**
  - With `mem_stall = 1`, `redirect_valid` is suppressed and the state does not change.
  - `ex_busy` = 1 whenever `mem_stall` is high.

## Timing
- **Reset:**
  - All `xm_*` = 0.
  - `redirect_valid` = 0, `redirect_pc` = 0.
  - `ex_busy` = 0; state = RUN.
  - Reset mid-REDIR drops the pending redirect.
- **Latency:** 1 cycle from ID/EX output to EX/MEM output.
- **Redirect:** combinational in the same cycle in RUN; registered in REDIR.
- `redirect_valid` and `redirect_pc` hold stable until `redirect_ready`.
- Simultaneous `mem_stall` and `redirect_ready` while in REDIR: the redirect completes and EX/MEM still holds.
- **Halt:** `xm_halt` is asserted for exactly the one captured entry.

## Configuration
- `EX_FORWARD_EN`
  - Defined: the forwarding network above is present.
  - Undefined: operands come directly from `rdat1_i`/`rdat2_i`, and the `wb_*` inputs are ignored. The hazard unit must then stall on every RAW hazard.

## Structure
- **Shared package (`cpu_types_pkg`):**
  - `ex_state_t` (RUN, REDIR, HALTED).
  - `rdsel_t` and `pcsrc_t` encodings.
  - Opcode constants.
- **Sub-module:** `ex_forward_unit`, a combinational operand-select block instantiated once per source register.

## Test plan
- **Reset:** hold `RST` 2 cycles with a non-bubble input → all `xm_*` = 0, state RUN.
- **ADD forwarding:** ADD $3,$1,$2 with `rdat1` = 5, `rdat2` = 7, followed by a dependent ADD $4,$3,$3 → first `xm_alu` = 12; second `xm_alu` = 24 via EX/MEM forwarding.
- **BEQ taken, fetch stalled:** `npc` = 0x104, imm = 3, equal operands, `redirect_ready` = 0 for 2 cycles → `redirect_pc` = 0x110 held; `ex_busy` = 1; EX/MEM gets bubbles. On the ready cycle the state returns to RUN.
- **JAL under memory stall:** `npc` = 0x204, `mem_stall` = 1 for 3 cycles → `redirect_valid` = 0 and EX/MEM unchanged while stalled. Then `xm_wsel` = 31, `xm_rdSel` = 2, `xm_npc` = 0x204.
- **Halt:** halt instruction → `xm_halt` = 1 for one cycle, then bubbles. `ex_busy` stays 1 until `RST`.
- **$0 destination:** `wb_wen` = 1 with `wb_wsel` = 0 and `wb_wdat` = 0xDEAD → no forwarding; operand = `rdat1_i`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline types, encodings and ALU helper
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL
  } aluop_t;

  typedef enum logic [1:0] {RUN, REDIR, HALTED} ex_state_t;

  typedef enum logic [2:0] {RD_ALU = 3'd0, RD_MEM = 3'd1, RD_NPC = 3'd2, RD_LUI = 3'd3} rdsel_t;

  typedef enum logic [1:0] {PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JIMM = 2'd2, PC_JR = 2'd3} pcsrc_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // One EX/MEM pipeline entry; an all-zero entry is a bubble
  typedef struct packed {
    word_t      instr;
    word_t      npc;
    word_t      alu;
    word_t      sdat;
    logic       regWr;
    logic       dWEN;
    logic       dREN;
    logic       halt;
    logic [2:0] rdSel;
    logic [4:0] wsel;
  } exmem_t;

  // Shifts take their amount from the instruction shamt field
  function automatic word_t aluCompute(aluop_t op, word_t a, word_t b, logic [4:0] shamt);
    word_t r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_SLL:  r = b << shamt;
      ALU_SRL:  r = b >> shamt;
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// rtl/ex_forward_unit.sv - operand select for one source register (EX_FORWARD_EN enables bypass)
module ex_forward_unit
  import cpu_types_pkg::*;
(
  input  logic [4:0] src,
  input  word_t      rfData,
  input  logic       xmRegWr,
  input  logic [4:0] xmWsel,
  input  logic       xmDREN,
  input  logic [2:0] xmRdSel,
  input  word_t      xmAlu,
  input  word_t      xmNpc,
  input  logic       wbWen,
  input  logic [4:0] wbWsel,
  input  word_t      wbWdat,
  output word_t      fwdData
);

`ifdef EX_FORWARD_EN
  // Youngest producer wins; $0 is never bypassed and loads are left to the hazard unit
  always_comb begin
    fwdData = rfData;
    if (xmRegWr && (xmWsel == src) && (xmWsel != 5'd0) && !xmDREN) begin
      fwdData = (xmRdSel == RD_NPC) ? xmNpc : xmAlu;
    end else if (wbWen && (wbWsel == src) && (wbWsel != 5'd0)) begin
      fwdData = wbWdat;
    end
  end
`else
  logic unusedFwd;
  assign unusedFwd = ^{src, xmRegWr, xmWsel, xmDREN, xmRdSel, xmAlu, xmNpc, wbWen, wbWsel, wbWdat};
  assign fwdData = rfData;
`endif

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage with redirect handshake and EX/MEM register (EX_FORWARD_EN)
module ex_stage
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  word_t      instr_i,
  input  word_t      npc_i,
  input  word_t      curr_pc_i,
  input  word_t      rdat1_i,
  input  word_t      rdat2_i,
  input  logic       regWr_i,
  input  logic       dWEN_i,
  input  logic       dREN_i,
  input  logic       jpSel_i,
  input  logic       aluSrc_i,
  input  logic       halt_i,
  input  aluop_t     aluOp_i,
  input  logic [2:0] rdSel_i,
  input  logic [1:0] pcSrc_i,
  input  logic       wb_wen,
  input  logic [4:0] wb_wsel,
  input  word_t      wb_wdat,
  input  logic       mem_stall,
  input  logic       redirect_ready,
  output logic       redirect_valid,
  output word_t      redirect_pc,
  output logic       ex_busy,
  output word_t      xm_instr,
  output word_t      xm_npc,
  output word_t      xm_alu,
  output word_t      xm_sdat,
  output logic       xm_regWr,
  output logic       xm_dWEN,
  output logic       xm_dREN,
  output logic       xm_halt,
  output logic [2:0] xm_rdSel,
  output logic [4:0] xm_wsel
);

  ex_state_t  state;
  word_t      latchedPc;
  exmem_t     xm;
  exmem_t     xmNext;
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd, shamt;
  logic       isBubble;
  word_t      immExt, fwdA, fwdB, opB, aluResult, target;
  logic       aluZero, branchTaken, takenNow, runRedirect;
  logic       unusedPc;

  assign opcode   = instr_i[31:26];
  assign rs       = instr_i[25:21];
  assign rt       = instr_i[20:16];
  assign rd       = instr_i[15:11];
  assign shamt    = instr_i[10:6];
  assign isBubble = (instr_i == '0);
  assign unusedPc = ^curr_pc_i;

  // Logical immediates zero-extend, everything else sign-extends
  always_comb begin
    immExt = {{16{instr_i[15]}}, instr_i[15:0]};
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
      immExt = {16'h0, instr_i[15:0]};
    end
  end

  ex_forward_unit fwdRs (
    .src(rs), .rfData(rdat1_i),
    .xmRegWr(xm.regWr), .xmWsel(xm.wsel), .xmDREN(xm.dREN), .xmRdSel(xm.rdSel),
    .xmAlu(xm.alu), .xmNpc(xm.npc),
    .wbWen(wb_wen), .wbWsel(wb_wsel), .wbWdat(wb_wdat),
    .fwdData(fwdA)
  );

  ex_forward_unit fwdRt (
    .src(rt), .rfData(rdat2_i),
    .xmRegWr(xm.regWr), .xmWsel(xm.wsel), .xmDREN(xm.dREN), .xmRdSel(xm.rdSel),
    .xmAlu(xm.alu), .xmNpc(xm.npc),
    .wbWen(wb_wen), .wbWsel(wb_wsel), .wbWdat(wb_wdat),
    .fwdData(fwdB)
  );

  assign opB       = aluSrc_i ? immExt : fwdB;
  assign aluResult = aluCompute(aluOp_i, fwdA, opB, shamt);
  assign aluZero   = (aluResult == '0);

  assign branchTaken = (opcode == OP_BEQ) ? aluZero : ((opcode == OP_BNE) ? !aluZero : 1'b0);
  assign takenNow    = !isBubble && ((pcSrc_i == PC_BR) ? branchTaken : (pcSrc_i != PC_SEQ));

  // Control-transfer target for the instruction currently in EX
  always_comb begin
    case (pcSrc_i)
      PC_BR:   target = npc_i + (immExt << 2);
      PC_JIMM: target = {npc_i[31:28], instr_i[25:0], 2'b00};
      PC_JR:   target = fwdA;
      default: target = npc_i;
    endcase
  end

  // A memory stall freezes RUN-state redirects; a pending REDIR keeps presenting its latched PC
  assign runRedirect    = (state == RUN) && takenNow && !mem_stall;
  assign redirect_valid = !RST && ((state == REDIR) || runRedirect);
  assign redirect_pc    = !redirect_valid ? '0 : ((state == REDIR) ? latchedPc : target);
  assign ex_busy        = mem_stall || (state != RUN);

  // Next EX/MEM entry: computed values only for a live instruction while running
  always_comb begin
    xmNext = '0;
    if (state == RUN && !isBubble) begin
      xmNext.instr = instr_i;
      xmNext.npc   = npc_i;
      xmNext.alu   = (rdSel_i == RD_LUI) ? {instr_i[15:0], 16'h0} : aluResult;
      xmNext.sdat  = fwdB;
      xmNext.regWr = regWr_i;
      xmNext.dWEN  = dWEN_i;
      xmNext.dREN  = dREN_i;
      xmNext.halt  = halt_i;
      xmNext.rdSel = rdSel_i;
      xmNext.wsel  = jpSel_i ? 5'd31 : ((opcode == OP_RTYPE) ? rd : rt);
    end
  end

  // Redirect/halt state machine; fetch that is not ready gets the target latched
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      latchedPc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!mem_stall && !isBubble) begin
            if (halt_i) begin
              state <= HALTED;
            end else if (takenNow && !redirect_ready) begin
              state     <= REDIR;
              latchedPc <= target;
            end
          end
        end
        REDIR:   if (redirect_ready) state <= RUN;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  // EX/MEM register holds while memory stalls
  always_ff @(posedge CLK) begin
    if (RST) begin
      xm <= '0;
    end else if (!mem_stall) begin
      xm <= xmNext;
    end
  end

  assign xm_instr = xm.instr;
  assign xm_npc   = xm.npc;
  assign xm_alu   = xm.alu;
  assign xm_sdat  = xm.sdat;
  assign xm_regWr = xm.regWr;
  assign xm_dWEN  = xm.dWEN;
  assign xm_dREN  = xm.dREN;
  assign xm_halt  = xm.halt;
  assign xm_rdSel = xm.rdSel;
  assign xm_wsel  = xm.wsel;

endmodule
